// File: rtl/kappa3_dbg_sequencer.sv
// Debug command sequencer: turns cmd/rsp transactions into timed strobes on the core debug port.
// Optional build macro KAPPA3_DBG_REGDUMP_EN enables op 7 (DUMP x0..x31, 32 responses).

module kappa3_dbg_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned STEP_TIMEOUT  = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [31:0] dbg_in,
   output logic [31:0] dbg_mem_addr,
   output logic [4:0]  dbg_reg_addr,
   output logic        dbg_pc_ld,
   output logic        dbg_reg_ld,
   output logic        dbg_mem_read,
   output logic        dbg_mem_write,
   output logic        step_inst,
   input  logic        running,
   input  logic [31:0] dbg_pc_out,
   input  logic [31:0] dbg_reg_out,
   input  logic [31:0] dbg_mem_out
);

   typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StSettle, StStepWait, StResp} state_e;

   localparam logic [2:0] OpWmem = 3'd0;
   localparam logic [2:0] OpRmem = 3'd1;
   localparam logic [2:0] OpWreg = 3'd2;
   localparam logic [2:0] OpRreg = 3'd3;
   localparam logic [2:0] OpWpc  = 3'd4;
   localparam logic [2:0] OpRpc  = 3'd5;
   localparam logic [2:0] OpStep = 3'd6;
   localparam logic [2:0] OpDump = 3'd7;

   localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] StepLimit  = 8'(STEP_TIMEOUT);

   state_e     state_q;
   logic [2:0] op_q;
   // Settle counter, or cycles since the step strobe while in StStepWait.
   logic [7:0] cnt_q;
   logic       op_illegal;
   logic       dump_more;

`ifdef KAPPA3_DBG_REGDUMP_EN
   logic [4:0] dump_idx_q;
   assign op_illegal = 1'b0;
   assign dump_more  = (op_q == OpDump) && (dump_idx_q != 5'd31);
`else
   assign op_illegal = (cmd_op == OpDump);
   assign dump_more  = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         op_q          <= 3'd0;
         cnt_q         <= 8'd0;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_data      <= 32'd0;
         rsp_err       <= 1'b0;
         dbg_in        <= 32'd0;
         dbg_mem_addr  <= 32'd0;
         dbg_reg_addr  <= 5'd0;
         dbg_pc_ld     <= 1'b0;
         dbg_reg_ld    <= 1'b0;
         dbg_mem_read  <= 1'b0;
         dbg_mem_write <= 1'b0;
         step_inst     <= 1'b0;
`ifdef KAPPA3_DBG_REGDUMP_EN
         dump_idx_q    <= 5'd0;
`endif
      end else begin
         dbg_pc_ld     <= 1'b0;
         dbg_reg_ld    <= 1'b0;
         dbg_mem_read  <= 1'b0;
         dbg_mem_write <= 1'b0;
         step_inst     <= 1'b0;
         case (state_q)
            StIdle: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready    <= 1'b0;
                  op_q         <= cmd_op;
                  dbg_in       <= cmd_data;
                  dbg_mem_addr <= cmd_addr;
                  dbg_reg_addr <= (cmd_op == OpDump) ? 5'd0 : cmd_addr[4:0];
                  rsp_data     <= 32'd0;
                  rsp_err      <= 1'b0;
                  cnt_q        <= 8'd0;
`ifdef KAPPA3_DBG_REGDUMP_EN
                  dump_idx_q   <= 5'd0;
`endif
                  if (op_illegal) begin
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state_q   <= StResp;
                  end else begin
                     state_q   <= StSetup;
                  end
               end
            end
            StSetup: begin
               case (op_q)
                  OpWmem:  dbg_mem_write <= 1'b1;
                  OpRmem:  dbg_mem_read  <= 1'b1;
                  OpWreg:  dbg_reg_ld    <= 1'b1;
                  OpWpc:   dbg_pc_ld     <= 1'b1;
                  OpStep:  step_inst     <= 1'b1;
                  default: ;
               endcase
               // Dump reads need no strobe, so they go straight to settling.
               state_q <= (op_q == OpDump) ? StSettle : StStrobe;
            end
            StStrobe: begin
               if (op_q == OpStep) begin
                  cnt_q   <= 8'd1;
                  state_q <= StStepWait;
               end else begin
                  cnt_q   <= 8'd0;
                  state_q <= StSettle;
               end
            end
            StSettle: begin
               if (cnt_q == SettleLast) begin
                  case (op_q)
                     OpRmem:  rsp_data <= dbg_mem_out;
                     OpRreg:  rsp_data <= dbg_reg_out;
                     OpRpc:   rsp_data <= dbg_pc_out;
                     OpDump:  rsp_data <= dbg_reg_out;
                     default: ;
                  endcase
                  cnt_q     <= 8'd0;
                  rsp_valid <= 1'b1;
                  state_q   <= StResp;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StStepWait: begin
               // running is ignored until two cycles after the strobe.
               if (cnt_q >= 8'd2 && !running) begin
                  cnt_q     <= 8'd0;
                  rsp_valid <= 1'b1;
                  state_q   <= StResp;
               end else if (cnt_q >= StepLimit) begin
                  cnt_q     <= 8'd0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state_q   <= StResp;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (dump_more) begin
                     rsp_data <= 32'd0;
                     state_q  <= StSetup;
`ifdef KAPPA3_DBG_REGDUMP_EN
                     dump_idx_q   <= dump_idx_q + 5'd1;
                     dbg_reg_addr <= dump_idx_q + 5'd1;
`endif
                  end else begin
                     cmd_ready <= 1'b1;
                     state_q   <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_kappa3_dbg_sequencer.sv
// Self-checking bench for kappa3_dbg_sequencer: directed and random commands against a
// behavioural model of memory, registers and PC, with a simple core model on the debug port.

module tb_kappa3_dbg_sequencer;

   localparam int unsigned SETTLE  = 2;
   localparam int unsigned STEP_TO = 255;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = 3'd0;
   logic [31:0] cmd_addr = 32'd0;
   logic [31:0] cmd_data = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [31:0] dbg_in, dbg_mem_addr;
   logic [4:0]  dbg_reg_addr;
   logic        dbg_pc_ld, dbg_reg_ld, dbg_mem_read, dbg_mem_write, step_inst;
   logic        running = 1'b0;
   logic [31:0] dbg_pc_out = 32'd0;
   logic [31:0] dbg_reg_out = 32'd0;
   logic [31:0] dbg_mem_out = 32'd0;

   kappa3_dbg_sequencer #(.SETTLE_CYCLES(SETTLE), .STEP_TIMEOUT(STEP_TO)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .dbg_in(dbg_in), .dbg_mem_addr(dbg_mem_addr), .dbg_reg_addr(dbg_reg_addr),
      .dbg_pc_ld(dbg_pc_ld), .dbg_reg_ld(dbg_reg_ld), .dbg_mem_read(dbg_mem_read),
      .dbg_mem_write(dbg_mem_write), .step_inst(step_inst), .running(running),
      .dbg_pc_out(dbg_pc_out), .dbg_reg_out(dbg_reg_out), .dbg_mem_out(dbg_mem_out)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] reg_init(int i);
      return (i == 0) ? 32'd0 : ((32'h9E37_79B9 * 32'(i)) ^ 32'h0F0F_0000);
   endfunction

   // Core model: reacts only to the debug strobes; x0 reads as zero.
   logic [31:0] mem [0:255];
   logic [31:0] regs [0:31];
   logic [31:0] pc = 32'd0;
   logic        core_init = 1'b0;
   int          busy = 2;
   int          run_left = 0;

   always @(posedge clock) begin
      if (!core_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
         for (int i = 0; i < 32; i++) regs[i] <= reg_init(i);
         core_init <= 1'b1;
      end else begin
         if (dbg_mem_write) mem[dbg_mem_addr[9:2]] <= dbg_in;
         if (dbg_reg_ld && dbg_reg_addr != 5'd0) regs[dbg_reg_addr] <= dbg_in;
         if (dbg_pc_ld) pc <= dbg_in;
      end
      if (step_inst) begin
         running  <= 1'b1;
         run_left <= busy - 1;
      end else if (running) begin
         if (run_left == 0) running <= 1'b0;
         else run_left <= run_left - 1;
      end
   end

   always @(negedge clock) begin
      dbg_mem_out <= mem[dbg_mem_addr[9:2]];
      dbg_reg_out <= regs[dbg_reg_addr];
      dbg_pc_out  <= pc;
   end

   // Strobe monitor: per-type counts, multi-hot count, and the context of the last strobe.
   int n_mw = 0, n_mr = 0, n_rl = 0, n_pl = 0, n_st = 0, multi = 0, st_cyc = 0;
   logic [31:0] st_addr = 32'd0, st_din = 32'd0;
   logic [4:0]  st_ridx = 5'd0;
   logic [2:0]  nstb;
   assign nstb = 3'(dbg_mem_write) + 3'(dbg_mem_read) + 3'(dbg_reg_ld) + 3'(dbg_pc_ld)
               + 3'(step_inst);

   always @(negedge clock) begin
      n_mw <= n_mw + int'(dbg_mem_write);
      n_mr <= n_mr + int'(dbg_mem_read);
      n_rl <= n_rl + int'(dbg_reg_ld);
      n_pl <= n_pl + int'(dbg_pc_ld);
      n_st <= n_st + int'(step_inst);
      if (nstb > 3'd1) multi <= multi + 1;
      if (nstb != 3'd0) begin
         st_cyc  <= cyc;
         st_addr <= dbg_mem_addr;
         st_din  <= dbg_in;
         st_ridx <= dbg_reg_addr;
      end
   end

   // Reference model, kept at transaction level.
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] ref_regs [0:31];
   logic [31:0] ref_pc = 32'd0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_rsp(output int rcyc);
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 400) begin
         @(negedge clock);
         n++;
      end
      if (n >= 400) chk("rsp_timeout", 64'(n), 64'(0));
      rcyc = cyc;
   endtask

   task automatic take_rsp(input int delay, output logic [31:0] rd, output logic re);
      logic [31:0] d0;
      logic        e0;
      int          bad = 0;
      d0 = rsp_data;
      e0 = rsp_err;
      repeat (delay) begin
         @(negedge clock);
         if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_err !== e0 || cmd_ready !== 1'b0)
            bad++;
      end
      if (delay > 0) chk("rsp_hold", 64'(bad), 64'(0));
      rd = rsp_data;
      re = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       output int acc);
      int n = 0;
      cmd_op = op;
      cmd_addr = addr;
      cmd_data = data;
      cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 64'(n), 64'(0));
      acc = cyc;
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input int delay);
      logic [31:0] ed = 32'd0, rd;
      logic        ee = 1'b0, re;
      int          acc, rcyc, lat;
      int          b_mw, b_mr, b_rl, b_pl, b_st;
      logic [4:0]  exp_stb = 5'd0;
      logic [4:0]  got_stb;
      b_mw = n_mw; b_mr = n_mr; b_rl = n_rl; b_pl = n_pl; b_st = n_st;
      case (op)
         3'd0: exp_stb = 5'b10000;
         3'd1: begin
            exp_stb = 5'b01000;
            ed = ref_mem.exists(addr) ? ref_mem[addr] : 32'd0;
         end
         3'd2: exp_stb = 5'b00100;
         3'd3: ed = ref_regs[addr[4:0]];
         3'd4: exp_stb = 5'b00010;
         3'd5: ed = ref_pc;
         3'd6: begin
            exp_stb = 5'b00001;
            ee = (busy >= int'(STEP_TO));
         end
         default: ee = 1'b1;
      endcase
      send(op, addr, data, acc);
      wait_rsp(rcyc);
      take_rsp(delay, rd, re);
      chk($sformatf("data op%0d", op), 64'(rd), 64'(ed));
      chk($sformatf("err op%0d", op), 64'(re), 64'(ee));
      got_stb = {n_mw != b_mw, n_mr != b_mr, n_rl != b_rl, n_pl != b_pl, n_st != b_st};
      chk($sformatf("strobes op%0d", op), 64'(got_stb), 64'(exp_stb));
      chk($sformatf("strobe_total op%0d", op),
          64'((n_mw - b_mw) + (n_mr - b_mr) + (n_rl - b_rl) + (n_pl - b_pl) + (n_st - b_st)),
          64'(exp_stb != 5'd0));
      if (exp_stb != 5'd0) begin
         chk($sformatf("strobe_lat op%0d", op), 64'(st_cyc - acc), 64'(2));
         chk($sformatf("strobe_ctx op%0d", op), {st_addr, st_din}, {addr, data});
         chk($sformatf("strobe_ridx op%0d", op), 64'(st_ridx), 64'(addr[4:0]));
      end
      if (op == 3'd6) begin
         lat = rcyc - st_cyc;
         if (ee) chk("step_timeout_lat", 64'(lat >= int'(STEP_TO) && lat <= int'(STEP_TO) + 3), 64'(1));
         else chk("step_lat", 64'(lat >= 3 && lat <= busy + 3), 64'(1));
      end
      case (op)
         3'd0: ref_mem[addr] = data;
         3'd2: if (addr[4:0] != 5'd0) ref_regs[addr[4:0]] = data;
         3'd4: ref_pc = data;
         default: ;
      endcase
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a, rd;
      logic        re;
      int          acc, rcyc, hits;
      for (int i = 0; i < 32; i++) ref_regs[i] = reg_init(i);

      repeat (3) @(negedge clock);
      chk("reset_ctrl", {cmd_ready, rsp_valid, rsp_err, dbg_pc_ld, dbg_reg_ld, dbg_mem_read,
                         dbg_mem_write, step_inst}, 64'(0));
      chk("reset_rsp_data", 64'(rsp_data), 64'(0));
      chk("reset_dbg", {dbg_in, dbg_mem_addr ^ {27'd0, dbg_reg_addr}}, 64'(0));
      chk("reset_reg_addr", 64'(dbg_reg_addr), 64'(0));
      reset = 1'b1;
      @(negedge clock);
      chk("ready_after_reset", 64'(cmd_ready), 64'(1));

      run_op(3'd0, 32'h100, 32'hDEAD_BEEF, 0);
      run_op(3'd1, 32'h100, 32'h0, 0);
      run_op(3'd2, 32'd5, 32'h1234_5678, 1);
      run_op(3'd3, 32'd5, 32'h0, 0);
      run_op(3'd4, 32'h0, 32'h200, 0);
      run_op(3'd5, 32'h0, 32'h0, 2);
      run_op(3'd2, 32'd0, 32'hFFFF_FFFF, 0);
      run_op(3'd3, 32'd0, 32'h0, 0);
      run_op(3'd1, 32'h100, 32'h0, 10);
      busy = 300;
      run_op(3'd6, 32'h0, 32'h0, 0);
      busy = 2;
      run_op(3'd6, 32'h0, 32'h0, 0);

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 6));
         if (op == 3'd0 || op == 3'd1) a = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
         else a = $urandom;
         if (op == 3'd6) busy = $urandom_range(1, 20);
         run_op(op, a, $urandom, $urandom_range(0, 3));
      end

      // Reset in the middle of SETTLE aborts the read with no response.
      send(3'd1, 32'h100, 32'h0, acc);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("abort_outputs", {cmd_ready, rsp_valid, dbg_pc_ld, dbg_reg_ld, dbg_mem_read,
                            dbg_mem_write, step_inst}, 64'(0));
      chk("abort_rsp_data", 64'(rsp_data), 64'(0));
      @(negedge clock);
      reset = 1'b1;
      hits = 0;
      repeat (10) begin
         @(negedge clock);
         if (rsp_valid !== 1'b0) hits++;
      end
      chk("abort_no_rsp", 64'(hits), 64'(0));
      chk("abort_ready", 64'(cmd_ready), 64'(1));
      run_op(3'd3, 32'd5, 32'h0, 0);

`ifdef KAPPA3_DBG_REGDUMP_EN
      send(3'd7, 32'h0, 32'h0, acc);
      hits = 0;
      for (int i = 0; i < 32; i++) begin
         wait_rsp(rcyc);
         if (cmd_ready !== 1'b0) hits++;
         take_rsp($urandom_range(0, 2), rd, re);
         chk($sformatf("dump_x%0d", i), {31'd0, re, rd}, {32'd0, ref_regs[i]});
      end
      chk("dump_ready_low", 64'(hits), 64'(0));
      hits = 0;
      repeat (6) begin
         @(negedge clock);
         if (rsp_valid !== 1'b0) hits++;
      end
      chk("dump_no_extra", 64'(hits), 64'(0));
      chk("dump_ready_after", 64'(cmd_ready), 64'(1));
`else
      run_op(3'd7, 32'h0, 32'h1111_1111, 0);
`endif

      chk("onehot_strobes", 64'(multi), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/kappa3_dbg_sequencer.md
KAPPA3_DBG_SEQUENCER -- requirements
Module: kappa3_dbg_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, idle cycles after each strobe before sampling or acking (1..15).
REQ-002 Parameter STEP_TIMEOUT, default 255, maximum cycles to wait for running to deassert after step_inst (1..255).
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low forces the reset state immediately.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  sequencer accepts a command this cycle.
REQ-007 cmd_op  in  3  0 WMEM, 1 RMEM, 2 WREG, 3 RREG, 4 WPC, 5 RPC, 6 STEP, 7 DUMP.
REQ-008 cmd_addr  in  32  memory address, or register index in bits [4:0].
REQ-009 cmd_data  in  32  write data.
REQ-010 rsp_valid  out  1  response word available.
REQ-011 rsp_ready  in  1  response consumed.
REQ-012 rsp_data  out  32  read result; 0 for writes and STEP.
REQ-013 rsp_err  out  1  illegal op or STEP timeout.
REQ-014 dbg_in, dbg_mem_addr  out  32 each  data and address to core debug port.
REQ-015 dbg_reg_addr  out  5  register index to core.
REQ-016 dbg_pc_ld, dbg_reg_ld, dbg_mem_read, dbg_mem_write, step_inst  out  1 each  one-cycle strobes to core.
REQ-017 running  in  1  core busy flag.
REQ-018 dbg_pc_out, dbg_reg_out, dbg_mem_out  in  32 each  core readback.

Function
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command transfers when cmd_valid and cmd_ready are both 1, and cmd_op/addr/data are latched then.
REQ-020 FSM states: IDLE, SETUP, STROBE, SETTLE, STEPWAIT, RESP.
REQ-021 On accept: IDLE->SETUP, driving latched dbg_in, dbg_mem_addr, and dbg_reg_addr (= cmd_addr[4:0]) for exactly 1 cycle.
REQ-022 SETUP->STROBE: one cycle with the op's strobe high (WMEM dbg_mem_write, RMEM dbg_mem_read, WREG dbg_reg_ld, WPC dbg_pc_ld, STEP step_inst; RREG/RPC none).
REQ-023 Addresses and data SHALL stay stable from SETUP until leaving SETTLE; at most one strobe is high in any cycle.
REQ-024 STROBE->SETTLE for SETTLE_CYCLES cycles; on the last SETTLE cycle, read ops capture dbg_mem_out / dbg_reg_out / dbg_pc_out into rsp_data; then go to RESP.
REQ-025 STEP: STROBE->STEPWAIT; leave when running==0, sampled no earlier than 2 cycles after the strobe; if STEP_TIMEOUT cycles elapse first, set rsp_err=1; then go to RESP.
REQ-026 RESP: rsp_valid=1 and rsp_data/rsp_err held stable until rsp_ready; on handshake go to IDLE (or the next DUMP step); back-to-back commands need no idle gap beyond this.
REQ-027 Every command SHALL produce exactly one response, except DUMP (REQ-031).
REQ-028 Illegal op (7 without macro): no strobe, go straight to RESP with rsp_err=1, rsp_data=0.
REQ-029 Writes to register index 0 SHALL still be strobed; the core owns x0 semantics.

Reset
REQ-030 While reset=0: state IDLE, all strobes 0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, dbg_in/dbg_mem_addr/dbg_reg_addr=0, counters 0. cmd_ready rises the first cycle after release. A reset mid-command aborts it without a response.

Configuration
REQ-031 Macro KAPPA3_DBG_REGDUMP_EN defined: DUMP reads x0..x31 in order, each via SETUP/SETTLE/RESP, giving 32 responses, each waiting on rsp_ready. cmd_ready stays 0 until the 32nd handshake.
REQ-032 Macro undefined: op 7 is illegal per REQ-028, and no dump counter logic is synthesized.

Verification
REQ-033 Reset release, then WMEM addr=0x100 data=0xDEADBEEF: dbg_mem_write high exactly 1 cycle, 2 cycles after accept, addr/data stable; then RMEM 0x100 -> rsp_data=0xDEADBEEF, rsp_err=0.
REQ-034 WREG x5=0x12345678, then RREG 5 -> 0x12345678; WPC 0x200, then RPC -> 0x00000200.
REQ-035 STEP with running held high 300 cycles -> rsp_err=1 after 255 cycles; STEP with running low 3 cycles after the strobe -> rsp_err=0.
REQ-036 rsp_ready held 0 for 10 cycles during RMEM -> rsp_valid and rsp_data stable, cmd_ready=0 throughout; reset pulled low mid-SETTLE -> all strobes 0 immediately and no response.
REQ-037 op 7: with macro, 32 responses equal x0..x31 contents, x0=0; without macro, one response with rsp_err=1, rsp_data=0.
